sti_deserializer: RTL and testbench
===================================

// Module: sti_deserializer
// PURPOSE
//  Serial-to-parallel receiver for the STI serial stream (data/valid bit interface).
//  Collects one 8/16/24/32-bit frame and strips zero padding per the frame config.
//  Recovers the original 16-bit word and queues it in a small output FIFO with valid/ready.
//  Placed at the receive end of the STI link, feeding the DAC/memory-write path.
// PARAMETERS
//  FIFO_DEPTH  4  output FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  reset       in   1   asynchronous, active-low; clears all state
//  cfg_load    in   1   latch cfg_* (accepted only in IDLE; ignored in RECV)
//  cfg_length  in   2   frame length: 00=8, 01=16, 10=24, 11=32 bits
//  cfg_fill    in   1   24/32-bit frames: 1=data in MSBs, pad in LSBs; 0=pad in MSBs
//  cfg_msb     in   1   1=MSB-first bit order, 0=LSB-first
//  cfg_low     in   1   8-bit frames: 1=byte goes to word[7:0], 0=byte goes to word[15:8]
//  si_data     in   1   serial bit, sampled when si_valid=1
//  si_valid    in   1   bit strobe; stays high for the whole frame
//  po_ready    in   1   consumer accepts FIFO head
//  po_data     out  16  recovered word (FIFO head)
//  po_pad_err  out  1   head word had a nonzero pad bit
//  po_valid    out  1   FIFO not empty
//  rx_busy     out  1   state==RECV
//  len_err     out  1   1-cycle pulse: si_valid fell before the frame was complete
//  ovf_err     out  1   1-cycle pulse: frame completed with FIFO full; word dropped
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, state IDLE, cfg = {00,0,0,0}, bit count 0.
//  - N = 8*(cfg_length+1). Bit index within frame cnt = 0..N-1.
//  - IDLE: si_valid=1 -> store bit 0, cnt<=1, go to RECV. cfg_load applies in IDLE only.
//  - RECV: si_valid=1 -> store bit, cnt++. On the bit at cnt==N-1: push word, go to IDLE.
//    si_valid=0 -> len_err pulse, discard partial frame, go to IDLE.
//  - Back-to-back frames: si_valid held high past bit N-1 starts the next frame
//    on the next cycle, with no gap.
//  - Bit placement (frame F[N-1:0]): MSB-first bit cnt -> F[N-1-cnt];
//    LSB-first bit cnt -> F[cnt]. Clear the frame register on frame start.
//  - Word extraction:
//      N=8:  low ? {8'h00,F[7:0]} : {F[7:0],8'h00}
//      N=16: F[15:0]
//      N=24: fill ? F[23:8], pad F[7:0]  : F[15:0], pad F[23:16]
//      N=32: fill ? F[31:16], pad F[15:0] : F[15:0], pad F[31:16]
//    pad_err = |pad; it is stored with the word.
//  - Latency: word and pad_err are written on the edge that samples the last bit.
//    po_valid is high in the following cycle. No combinational bypass.
//  - FIFO: pop when po_valid & po_ready. Strict order is kept.
//    Push with pop on the same edge when full: both happen, no ovf_err.
//    Push when full with no pop: word dropped, ovf_err pulse.
//    Pop when empty: no effect.
//  - len_err and ovf_err are registered single-cycle pulses.
//  - Reset asserted mid-frame: frame discarded, FIFO flushed, no error pulses.
// STRUCTURE
//  - Shared package sti_pkg:
//    length encodings LEN_8/16/24/32, state enum {IDLE,RECV}, width WORD_W=16.
//  - Sub-module sti_rx_fifo: 17-bit wide x FIFO_DEPTH, push/pop/full/empty.
//    Top level holds the FSM, counter, frame register and extraction logic.
// TESTING
//  1. len=01, msb=1, stream 16'hA5C3, po_ready=1 -> one po_valid cycle after last bit,
//     po_data=A5C3, po_pad_err=0.
//  2. len=00, msb=0, byte 8'h3C -> low=0 gives 3C00; low=1 gives 003C.
//  3. len=11, fill=1, msb=1, 32'h1234_0000 -> 1234, pad_err=0.
//     fill=0 with 32'h0001_1234 -> 1234, pad_err=1.
//  4. len=01, si_valid drops after 10 bits -> len_err pulse, no push.
//     The next full frame is received correctly.
//  5. FIFO_DEPTH=4, po_ready=0, 5 back-to-back 8-bit frames ->
//     4 stored, ovf_err pulse on the 5th, drain order is frames 1..4.
//  6. reset low at bit 7 of a 24-bit frame -> outputs 0, FIFO empty.
//     cfg_load during RECV is ignored; the next frame decodes with the old cfg.

Source files
------------

// File: rtl/sti_pkg.sv
// Shared definitions for the STI serial receive path.
//   - frame-length encodings, FSM state constants, word/frame widths
//   - cfg_t: latched frame configuration
//   - entry_t: one output FIFO entry {pad_err, word}
//   - extract_word(): strips padding from an assembled frame
package sti_pkg;

  localparam int WORD_W  = 16;
  localparam int FRAME_W = 32;
  localparam int CNT_W   = 5;   // bit index 0..31

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  typedef struct packed {
    logic [1:0] length;
    logic       fill;
    logic       msb;
    logic       low;
  } cfg_t;

  typedef struct packed {
    logic              pad_err;
    logic [WORD_W-1:0] word;
  } entry_t;

  // Recover the 16-bit word from a frame; pad_err flags any nonzero pad bit.
  function automatic entry_t extract_word(input logic [FRAME_W-1:0] f,
                                          input logic [1:0]         length,
                                          input logic               fill,
                                          input logic               low);
    entry_t e;
    e = '0;
    case (length)
      LEN_8:  e.word = low ? {8'h00, f[7:0]} : {f[7:0], 8'h00};
      LEN_16: e.word = f[15:0];
      LEN_24: begin
        if (fill) begin
          e.word    = f[23:8];
          e.pad_err = |f[7:0];
        end else begin
          e.word    = f[15:0];
          e.pad_err = |f[23:16];
        end
      end
      default: begin
        if (fill) begin
          e.word    = f[31:16];
          e.pad_err = |f[15:0];
        end else begin
          e.word    = f[15:0];
          e.pad_err = |f[31:16];
        end
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sti_rx_fifo.sv
// Output FIFO for recovered STI words.
//   clk, reset (async, active-low)
//   push/wr_data : write request and entry
//   pop          : read request (ignored when empty)
//   rd_data      : head entry (undefined when empty)
//   full, empty  : status
// A push while full is accepted only if a pop happens on the same edge.
module sti_rx_fifo
  import sti_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  entry_t wr_data,
  output entry_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/sti_deserializer.sv
// STI serial-to-parallel receiver.
//   clk, reset (async, active-low)
//   cfg_load, cfg_length, cfg_fill, cfg_msb, cfg_low : frame config, latched in IDLE
//   si_data, si_valid : serial bit and per-bit strobe (high for a whole frame)
//   po_ready          : consumer accepts FIFO head
//   po_data, po_pad_err, po_valid : FIFO head word, its pad flag, FIFO not empty
//   rx_busy           : frame reception in progress
//   len_err, ovf_err  : 1-cycle pulses for a truncated frame / dropped word
module sti_deserializer
  import sti_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_length,
  input  logic              cfg_fill,
  input  logic              cfg_msb,
  input  logic              cfg_low,
  input  logic              si_data,
  input  logic              si_valid,
  input  logic              po_ready,
  output logic [WORD_W-1:0] po_data,
  output logic              po_pad_err,
  output logic              po_valid,
  output logic              rx_busy,
  output logic              len_err,
  output logic              ovf_err
);

  logic [0:0]         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;
  cfg_t               cfg_q;

  logic [1:0]         eff_length;
  logic               eff_msb;
  logic [CNT_W-1:0]   last_idx;
  logic [CNT_W-1:0]   bit_pos;
  logic               in_idle;
  logic               last_bit;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  entry_t             push_entry;
  entry_t             head;

  assign in_idle = (state_q == IDLE);

  // A frame may start on the same edge that loads a new config, so bit 0 is
  // placed using the config about to be latched rather than the stale one.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    eff_length = cfg_q.length;
    eff_msb    = cfg_q.msb;
    if (in_idle && cfg_load) begin
      eff_length = cfg_length;
      eff_msb    = cfg_msb;
    end
    last_idx = {eff_length, 3'b111};               // N-1
    bit_pos  = eff_msb ? (last_idx - cnt_q) : cnt_q;
    // Frame register is cleared when a new frame starts.
    frame_d          = in_idle ? '0 : frame_q;
    frame_d[bit_pos] = si_data;
  end

  assign last_bit   = !in_idle && si_valid && (cnt_q == last_idx);
  assign push       = last_bit;
  // Only reached in RECV, where cfg_q is the config in force for the frame.
  assign push_entry = extract_word(frame_d, cfg_q.length, cfg_q.fill, cfg_q.low);
  assign pop        = po_valid && po_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      cfg_q   <= '0;
      len_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      len_err <= 1'b0;
      // Full implies po_valid, so a pop happens exactly when po_ready is high.
      ovf_err <= push && fifo_full && !po_ready;

      if (in_idle && cfg_load) begin
        cfg_q <= '{length: cfg_length, fill: cfg_fill, msb: cfg_msb, low: cfg_low};
      end

      if (in_idle) begin
        if (si_valid) begin
          state_q <= RECV;
          cnt_q   <= CNT_W'(1);
          frame_q <= frame_d;
        end
      end else begin
        if (!si_valid) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          len_err <= 1'b1;
        end else if (last_bit) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          frame_q <= frame_d;
        end else begin
          cnt_q   <= cnt_q + CNT_W'(1);
          frame_q <= frame_d;
        end
      end
    end
  end

  sti_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (push_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head is forced to zero when empty so outputs are clean out of reset.
  assign po_valid   = !fifo_empty;
  assign po_data    = fifo_empty ? '0 : head.word;
  assign po_pad_err = fifo_empty ? 1'b0 : head.pad_err;
  assign rx_busy    = (state_q == RECV);

endmodule

// File: tb/tb_sti_deserializer.sv
// Self-checking bench for sti_deserializer: directed scenarios plus randomized
// frames, compared against a frame-level reference model and an expected-word queue.
module tb_sti_deserializer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_load = 1'b0;
  logic [1:0]  cfg_length = 2'b00;
  logic        cfg_fill = 1'b0;
  logic        cfg_msb = 1'b0;
  logic        cfg_low = 1'b0;
  logic        si_data = 1'b0;
  logic        si_valid = 1'b0;
  logic        po_ready = 1'b0;
  logic [15:0] po_data;
  logic        po_pad_err;
  logic        po_valid;
  logic        rx_busy;
  logic        len_err;
  logic        ovf_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_q[$];          // expected FIFO contents {pad_err, word}
  logic [1:0]  m_len  = 2'b00;    // model of the latched config
  bit          m_fill = 1'b0;
  bit          m_msb  = 1'b0;
  bit          m_low  = 1'b0;

  sti_deserializer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_load   (cfg_load),
    .cfg_length (cfg_length),
    .cfg_fill   (cfg_fill),
    .cfg_msb    (cfg_msb),
    .cfg_low    (cfg_low),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .po_ready   (po_ready),
    .po_data    (po_data),
    .po_pad_err (po_pad_err),
    .po_valid   (po_valid),
    .rx_busy    (rx_busy),
    .len_err    (len_err),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word recovery from the frame value using shift/mask arithmetic.
  function automatic logic [16:0] model_word(input logic [31:0] f, input int n,
                                             input bit fill, input bit low);
    logic [31:0] word;
    logic [31:0] padv;
    int          pb;
    padv = 32'd0;
    if (n == 8) begin
      word = low ? (f & 32'hFF) : ((f & 32'hFF) * 256);
    end else if (n == 16) begin
      word = f & 32'hFFFF;
    end else begin
      pb = n - 16;
      if (fill) begin
        word = (f >> pb) & 32'hFFFF;
        padv = f & ((32'd1 << pb) - 1);
      end else begin
        word = f & 32'hFFFF;
        padv = f >> 16;
      end
    end
    return {padv != 0, word[15:0]};
  endfunction

  task automatic load_cfg(input logic [1:0] len, input bit fill, input bit msb, input bit low);
    cfg_length = len;
    cfg_fill   = fill;
    cfg_msb    = msb;
    cfg_low    = low;
    cfg_load   = 1'b1;
    tick();
    cfg_load   = 1'b0;
    m_len  = len;
    m_fill = fill;
    m_msb  = msb;
    m_low  = low;
  endtask

  // Serialize one frame with the model config. glitch_at >= 0 pulses cfg_load
  // (with different values) during that bit, which must have no effect.
  task automatic send_frame(input logic [31:0] f_in, input bit keep, input bit pop_last,
                            input int glitch_at);
    int          n;
    logic [31:0] f;
    logic [16:0] ent;
    bit          exp_ovf;
    n   = 8 * (int'(m_len) + 1);
    f   = (n == 32) ? f_in : (f_in & ((32'd1 << n) - 1));
    ent = model_word(f, n, m_fill, m_low);
    for (int k = 0; k < n; k++) begin
      si_valid = 1'b1;
      si_data  = m_msb ? f[n-1-k] : f[k];
      if (k == glitch_at) begin
        cfg_load   = 1'b1;
        cfg_length = ~m_len;
        cfg_fill   = ~m_fill;
        cfg_msb    = ~m_msb;
        cfg_low    = ~m_low;
      end else begin
        cfg_load = 1'b0;
      end
      if (k == n - 1) begin
        check("busy_last_bit", rx_busy, 1);
        check("valid_before_push", po_valid, exp_q.size() != 0);
        if (pop_last) begin
          po_ready = 1'b1;
          check("head_at_pop", {po_pad_err, po_data}, exp_q[0]);
        end
      end
      tick();
    end
    cfg_load = 1'b0;
    if (pop_last) begin
      po_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    exp_ovf = 1'b0;
    if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(ent);
    check("ovf_err", ovf_err, exp_ovf);
    check("busy_after_frame", rx_busy, 0);
    check("valid_after_frame", po_valid, exp_q.size() != 0);
    if (!keep) si_valid = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    logic [16:0] e;
    po_ready = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, po_valid, 1);
      check({tag, "_data"}, po_data, e[15:0]);
      check({tag, "_pad"}, po_pad_err, e[16]);
      tick();
    end
    check({tag, "_empty"}, po_valid, 0);
    po_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int          cnt;

    // Reset state
    tick();
    tick();
    check("rst_po_valid", po_valid, 0);
    check("rst_po_data", po_data, 0);
    check("rst_pad", po_pad_err, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_len_err", len_err, 0);
    check("rst_ovf_err", ovf_err, 0);
    reset = 1'b1;
    tick();

    // 1: 16-bit MSB-first, consumer ready
    load_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    po_ready = 1'b1;
    send_frame(32'h0000_A5C3, 1'b0, 1'b0, -1);
    check("t1_data_lit", po_data, 16'hA5C3);
    drain_check("t1");

    // 2: 8-bit LSB-first, low=0 then low=1
    load_cfg(2'b00, 1'b0, 1'b0, 1'b0);
    send_frame(32'h3C, 1'b0, 1'b0, -1);
    load_cfg(2'b00, 1'b0, 1'b0, 1'b1);
    send_frame(32'h3C, 1'b0, 1'b0, -1);
    check("t2_head_lit", po_data, 16'h3C00);
    drain_check("t2");

    // 3: 32-bit, fill=1 clean pad, fill=0 dirty pad
    load_cfg(2'b11, 1'b1, 1'b1, 1'b0);
    send_frame(32'h1234_0000, 1'b0, 1'b0, -1);
    load_cfg(2'b11, 1'b0, 1'b1, 1'b0);
    send_frame(32'h0001_1234, 1'b0, 1'b0, -1);
    drain_check("t3");

    // 4: truncated 16-bit frame, then a good one
    load_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      si_valid = 1'b1;
      si_data  = 1'($urandom_range(1, 0));
      tick();
    end
    check("t4_busy_mid", rx_busy, 1);
    si_valid = 1'b0;
    tick();
    check("t4_len_err", len_err, 1);
    check("t4_busy_off", rx_busy, 0);
    check("t4_no_push", po_valid, 0);
    tick();
    check("t4_len_err_pulse", len_err, 0);
    send_frame($urandom, 1'b0, 1'b0, -1);
    drain_check("t4");

    // 5: five back-to-back bytes into a 4-deep FIFO with no consumer
    load_cfg(2'b00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_frame($urandom, i < 4, 1'b0, -1);
    tick();
    check("t5_ovf_pulse", ovf_err, 0);
    drain_check("t5");

    // Push and pop on the same edge while full: no drop
    for (int i = 0; i < 5; i++) send_frame($urandom, i < 4, i == 4, -1);
    drain_check("t5b");

    // 6: reset mid 24-bit frame with a non-empty FIFO
    send_frame($urandom, 1'b0, 1'b0, -1);
    load_cfg(2'b10, 1'b1, 1'b1, 1'b0);
    r = $urandom;
    for (int k = 0; k < 7; k++) begin
      si_valid = 1'b1;
      si_data  = r[23-k];
      tick();
    end
    si_data = r[16];
    #2 reset = 1'b0;
    #1;
    check("t6_po_valid", po_valid, 0);
    check("t6_po_data", po_data, 0);
    check("t6_pad", po_pad_err, 0);
    check("t6_busy", rx_busy, 0);
    check("t6_len_err", len_err, 0);
    check("t6_ovf_err", ovf_err, 0);
    si_valid = 1'b0;
    exp_q.delete();
    m_len  = 2'b00;
    m_fill = 1'b0;
    m_msb  = 1'b0;
    m_low  = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("t6_no_len_err", len_err, 0);
    check("t6_idle", rx_busy, 0);

    // Config after reset is 8-bit, LSB-first, byte to high half
    send_frame(32'h5A, 1'b0, 1'b0, -1);
    check("t6_default_cfg", po_data, 16'h5A00);
    drain_check("t6_dflt");

    // cfg_load during RECV is ignored
    load_cfg(2'b01, 1'b0, 1'b1, 1'b0);
    send_frame($urandom, 1'b0, 1'b0, 3);
    send_frame($urandom, 1'b0, 1'b0, -1);
    drain_check("t6_glitch");

    // Randomized configs and frame bursts
    for (int rr = 0; rr < 10; rr++) begin
      load_cfg(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      cnt = $urandom_range(DEPTH, 1);
      for (int i = 0; i < cnt; i++) send_frame($urandom, i < cnt - 1, 1'b0, -1);
      drain_check("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
